// File: rtl/galois_lfsr_checker_if.sv
// galois_lfsr_checker_if
// Bundles the control, stream and status signals of the Galois LFSR checker.
//   master : the side driving the stream (testbench / link front end)
//   slave  : the checker itself
// Signals:
//   clr, ld, taps[N], lfsr_i[N], din, din_vld       -> checker
//   locked, err_pulse, err_cnt[CNT_W], bit_cnt[CNT_W], lfsr_o[N] <- checker
interface galois_lfsr_checker_if #(
  parameter int N     = 32,
  parameter int CNT_W = 16
);
  logic             clr;
  logic             ld;
  logic [N-1:0]     taps;
  logic [N-1:0]     lfsr_i;
  logic             din;
  logic             din_vld;
  logic             locked;
  logic             err_pulse;
  logic [CNT_W-1:0] err_cnt;
  logic [CNT_W-1:0] bit_cnt;
  logic [N-1:0]     lfsr_o;

  modport master (
    output clr, ld, taps, lfsr_i, din, din_vld,
    input  locked, err_pulse, err_cnt, bit_cnt, lfsr_o
  );

  modport slave (
    input  clr, ld, taps, lfsr_i, din, din_vld,
    output locked, err_pulse, err_cnt, bit_cnt, lfsr_o
  );
endinterface

// File: rtl/galois_lfsr_checker.sv
// galois_lfsr_checker
// Receive-side checker for a Galois LFSR keystream/PRBS. A local LFSR is
// aligned to the incoming MSB stream (SEARCH), lock is declared after
// LOCK_CNT consecutive matches, and while LOCKED every valid bit and every
// mismatch is counted with saturating counters. LOSS_CNT consecutive
// mismatches while LOCKED drop back to SEARCH.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : galois_lfsr_checker_if.slave (clr, ld, taps, lfsr_i, din, din_vld
//          in; locked, err_pulse, err_cnt, bit_cnt, lfsr_o out)
module galois_lfsr_checker #(
  parameter int N        = 32,
  parameter int LOCK_CNT = 32,
  parameter int LOSS_CNT = 8,
  parameter int CNT_W    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  galois_lfsr_checker_if.slave  bus
);

  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam int LW = $clog2(LOSS_CNT + 1);
  localparam logic [CNT_W-1:0] CMAX = '1;

  typedef enum logic {SEARCH, LOCKED} state_e;

  state_e           state_q, state_d;
  logic [N-1:0]     lfsr_q, lfsr_d;
  logic [MW-1:0]    match_q, match_d;
  logic [LW-1:0]    miss_q, miss_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic             err_pulse_q, err_pulse_d;

  function automatic logic [N-1:0] step(input logic [N-1:0] s,
                                        input logic [N-1:0] t);
    return {s[N-2:0], 1'b0} ^ (t & {N{s[N-1]}});
  endfunction

  logic [N-1:0] step1, step2;
  logic         hit;

  assign step1 = step(lfsr_q, bus.taps);
  assign step2 = step(step1, bus.taps);
  assign hit   = (bus.din == lfsr_q[N-1]);

  always_comb begin
    state_d     = state_q;
    lfsr_d      = lfsr_q;
    match_d     = match_q;
    miss_d      = miss_q;
    err_cnt_d   = err_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    err_pulse_d = 1'b0;

    if (bus.ld) begin
      lfsr_d  = bus.lfsr_i;
      state_d = SEARCH;
      match_d = '0;
      miss_d  = '0;
    end else if (bus.din_vld) begin
      case (state_q)
        SEARCH: begin
          if (hit) begin
            lfsr_d = step1;
            if (match_q == MW'(LOCK_CNT - 1)) begin
              state_d = LOCKED;
              match_d = '0;
            end else begin
              match_d = match_q + MW'(1);
            end
          end else begin
            // Slip the local generator one bit ahead so that a stream which
            // is ahead of the local seed is eventually caught.
            lfsr_d  = step2;
            match_d = '0;
          end
        end
        LOCKED: begin
          lfsr_d = step1;
          if (bit_cnt_q != CMAX) bit_cnt_d = bit_cnt_q + CNT_W'(1);
          if (!hit) begin
            if (err_cnt_q != CMAX) err_cnt_d = err_cnt_q + CNT_W'(1);
            err_pulse_d = 1'b1;
            if (miss_q == LW'(LOSS_CNT - 1)) begin
              state_d = SEARCH;
              miss_d  = '0;
              match_d = '0;
            end else begin
              miss_d = miss_q + LW'(1);
            end
          end else begin
            miss_d = '0;
          end
        end
        default: state_d = SEARCH;
      endcase
    end

    // clr only touches the statistics; the lock machine still sees the bit.
    if (bus.clr) begin
      err_cnt_d   = '0;
      bit_cnt_d   = '0;
      err_pulse_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= SEARCH;
      lfsr_q      <= '1;
      match_q     <= '0;
      miss_q      <= '0;
      err_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      err_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      match_q     <= match_d;
      miss_q      <= miss_d;
      err_cnt_q   <= err_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      err_pulse_q <= err_pulse_d;
    end
  end

  assign bus.locked    = (state_q == LOCKED);
  assign bus.err_pulse = err_pulse_q;
  assign bus.err_cnt   = err_cnt_q;
  assign bus.bit_cnt   = bit_cnt_q;
  assign bus.lfsr_o    = lfsr_q;

endmodule

// File: tb/tb_galois_lfsr_checker.sv
// tb_galois_lfsr_checker
// Randomized self-checking bench for galois_lfsr_checker (N=8, LOCK_CNT=4,
// LOSS_CNT=8, CNT_W=4). A behavioural model of the checker and a reference
// generator are kept here; each scenario task compares DUT outputs inline.
module tb_galois_lfsr_checker;
  localparam int N = 8, LOCK_CNT = 4, LOSS_CNT = 8, CNT_W = 4;
  localparam int CMAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  galois_lfsr_checker_if #(.N(N), .CNT_W(CNT_W)) bus ();

  galois_lfsr_checker #(.N(N), .LOCK_CNT(LOCK_CNT), .LOSS_CNT(LOSS_CNT),
                        .CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int total = 0;
  int passed = 0;

  logic [7:0] taps;
  logic [7:0] g;          // reference generator state
  // behavioural model of the checker
  logic [7:0] m_lfsr;
  bit         m_locked, m_pulse;
  int         m_match, m_miss, m_err, m_bit;

  function automatic logic [7:0] mstep(input logic [7:0] s);
    int v;
    v = (int'(s) * 2) % 256;
    if (s >= 8'h80) v = v ^ int'(taps);
    return 8'(v);
  endfunction

  function automatic int sat(input int v);
    return (v < CMAX) ? v + 1 : CMAX;
  endfunction

  task automatic cyc(input logic r, input logic l, input logic c,
                     input logic d, input logic v, input logic [7:0] seed);
    logic expb;
    @(negedge clk);
    rst = r; bus.ld = l; bus.clr = c; bus.din = d; bus.din_vld = v;
    bus.lfsr_i = seed; bus.taps = taps;
    @(posedge clk);
    #1;
    if (r) begin
      m_lfsr = 8'hFF; m_locked = 0; m_match = 0; m_miss = 0;
      m_err = 0; m_bit = 0; m_pulse = 0;
    end else begin
      m_pulse = 0;
      if (l) begin
        m_lfsr = seed; m_locked = 0; m_match = 0; m_miss = 0;
      end else if (v) begin
        expb = m_lfsr[7];
        if (!m_locked) begin
          if (d == expb) begin
            m_lfsr = mstep(m_lfsr);
            m_match++;
            if (m_match == LOCK_CNT) begin m_locked = 1; m_match = 0; end
          end else begin
            m_lfsr = mstep(mstep(m_lfsr));
            m_match = 0;
          end
        end else begin
          m_lfsr = mstep(m_lfsr);
          m_bit = sat(m_bit);
          if (d != expb) begin
            m_err = sat(m_err); m_pulse = 1; m_miss++;
            if (m_miss == LOSS_CNT) begin m_locked = 0; m_miss = 0; m_match = 0; end
          end else m_miss = 0;
        end
      end
      if (c) begin m_err = 0; m_bit = 0; m_pulse = 0; end
    end
  endtask

  // one stream bit from the reference generator, optionally inverted
  task automatic send(input logic flip, input logic v, input logic c);
    cyc(1'b0, 1'b0, c, g[7] ^ flip, v, 8'h00);
    if (v) g = mstep(g);
  endtask

  task automatic resync();
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, g);
    for (int i = 0; i < LOCK_CNT; i++) send(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic test_reset();
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    total++; if (bus.locked !== 1'b0) $display("FAIL reset_locked got %0b want 0", bus.locked); else passed++;
    total++; if (bus.err_pulse !== 1'b0) $display("FAIL reset_pulse got %0b want 0", bus.err_pulse); else passed++;
    total++; if (bus.err_cnt !== 4'd0) $display("FAIL reset_err got %0d want 0", bus.err_cnt); else passed++;
    total++; if (bus.bit_cnt !== 4'd0) $display("FAIL reset_bit got %0d want 0", bus.bit_cnt); else passed++;
    total++; if (bus.lfsr_o !== 8'hFF) $display("FAIL reset_lfsr got %0h want ff", bus.lfsr_o); else passed++;
  endtask

  task automatic test_lock_matched();
    logic [7:0] exp_st [3];
    exp_st[0] = 8'hE3; exp_st[1] = 8'hDB; exp_st[2] = 8'hAB;
    g = 8'hFF;
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'hFF);
    for (int i = 0; i < LOCK_CNT; i++) begin
      send(1'b0, 1'b1, 1'b0);
      if (i < 3) begin
        total++; if (bus.lfsr_o !== exp_st[i]) $display("FAIL match_state%0d got %0h want %0h", i, bus.lfsr_o, exp_st[i]); else passed++;
      end
      total++; if (bus.locked !== (i == LOCK_CNT - 1)) $display("FAIL match_locked%0d got %0b want %0b", i, bus.locked, i == LOCK_CNT - 1); else passed++;
    end
    for (int i = 1; i <= 6; i++) begin
      send(1'b0, 1'b1, 1'b0);
      total++; if (bus.bit_cnt !== 4'(i)) $display("FAIL match_bitcnt got %0d want %0d", bus.bit_cnt, i); else passed++;
    end
    total++; if (bus.err_cnt !== 4'd0) $display("FAIL match_err got %0d want 0", bus.err_cnt); else passed++;
  endtask

  task automatic test_offset();
    logic [7:0] s;
    bool_loop: begin end
    s = 8'($urandom_range(1, 255));
    g = mstep(mstep(mstep(s)));
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, s);
    for (int i = 0; i < 120 && !(m_locked && bus.locked); i++) begin
      send(1'b0, 1'($urandom_range(0, 3) != 0), 1'b0);
      total++; if (bus.locked !== m_locked || bus.lfsr_o !== m_lfsr)
        $display("FAIL offset_track got %0b/%0h want %0b/%0h", bus.locked, bus.lfsr_o, m_locked, m_lfsr); else passed++;
    end
    total++; if (bus.locked !== 1'b1) $display("FAIL offset_lock got %0b want 1 within budget", bus.locked); else passed++;
    total++; if (bus.err_cnt !== 4'(m_err)) $display("FAIL offset_err got %0d want %0d", bus.err_cnt, m_err); else passed++;
  endtask

  task automatic test_errors();
    int p1, p2, pulses;
    resync();
    p1 = $urandom_range(2, 8);
    p2 = $urandom_range(p1 + 2, 16);
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      send(1'(i == p1 || i == p2), 1'b1, 1'b0);
      if (bus.err_pulse === 1'b1) pulses++;
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    if (bus.err_pulse === 1'b1) pulses++;
    total++; if (pulses != 2) $display("FAIL err_pulses got %0d want 2", pulses); else passed++;
    total++; if (bus.err_cnt !== 4'd2) $display("FAIL err_cnt got %0d want 2", bus.err_cnt); else passed++;
    total++; if (bus.locked !== 1'b1) $display("FAIL err_locked got %0b want 1", bus.locked); else passed++;
    total++; if (bus.bit_cnt !== 4'(m_bit)) $display("FAIL err_bitcnt got %0d want %0d", bus.bit_cnt, m_bit); else passed++;
  endtask

  task automatic test_loss();
    resync();
    for (int i = 1; i <= LOSS_CNT; i++) begin
      send(1'b1, 1'b1, 1'b0);
      total++; if (bus.locked !== (i < LOSS_CNT)) $display("FAIL loss_locked%0d got %0b want %0b", i, bus.locked, i < LOSS_CNT); else passed++;
    end
    total++; if (bus.err_cnt !== 4'd8) $display("FAIL loss_err got %0d want 8", bus.err_cnt); else passed++;
    total++; if (bus.bit_cnt !== 4'd8) $display("FAIL loss_bit got %0d want 8", bus.bit_cnt); else passed++;
    for (int i = 1; i <= LOCK_CNT; i++) begin
      send(1'b0, 1'b1, 1'b0);
      total++; if (bus.locked !== (i == LOCK_CNT)) $display("FAIL relock%0d got %0b want %0b", i, bus.locked, i == LOCK_CNT); else passed++;
    end
  endtask

  task automatic test_saturation();
    resync();
    for (int i = 0; i < 20; i++) begin
      if ($urandom_range(0, 1) == 1) send(1'b0, 1'b0, 1'b0);
      send(1'b1, 1'b1, 1'b0);
      send(1'b0, 1'b1, 1'b0);
    end
    total++; if (bus.err_cnt !== 4'd15) $display("FAIL sat_err got %0d want 15", bus.err_cnt); else passed++;
    total++; if (bus.bit_cnt !== 4'd15) $display("FAIL sat_bit got %0d want 15", bus.bit_cnt); else passed++;
    total++; if (bus.locked !== 1'b1) $display("FAIL sat_locked got %0b want 1", bus.locked); else passed++;
    send(1'b1, 1'b1, 1'b1);
    total++; if (bus.err_cnt !== 4'd0) $display("FAIL clr_err got %0d want 0", bus.err_cnt); else passed++;
    total++; if (bus.bit_cnt !== 4'd0) $display("FAIL clr_bit got %0d want 0", bus.bit_cnt); else passed++;
    total++; if (bus.err_pulse !== 1'b0) $display("FAIL clr_pulse got %0b want 0", bus.err_pulse); else passed++;
    total++; if (bus.locked !== 1'b1) $display("FAIL clr_locked got %0b want 1", bus.locked); else passed++;
  endtask

  task automatic test_reset_load();
    logic [7:0] s;
    resync();
    send(1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00);
    total++; if (bus.locked !== 1'b0 || bus.err_pulse !== 1'b0 || bus.err_cnt !== 4'd0 || bus.bit_cnt !== 4'd0)
      $display("FAIL rst_mid got %0b/%0b/%0d/%0d want 0/0/0/0", bus.locked, bus.err_pulse, bus.err_cnt, bus.bit_cnt); else passed++;
    total++; if (bus.lfsr_o !== 8'hFF) $display("FAIL rst_mid_lfsr got %0h want ff", bus.lfsr_o); else passed++;
    s = 8'($urandom_range(0, 255));
    cyc(1'b0, 1'b1, 1'b0, 1'($urandom_range(0, 1)), 1'b1, s);
    total++; if (bus.lfsr_o !== s) $display("FAIL ld_vld got %0h want %0h", bus.lfsr_o, s); else passed++;
    total++; if (bus.locked !== 1'b0) $display("FAIL ld_locked got %0b want 0", bus.locked); else passed++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] s;
    taps = 8'($urandom_range(0, 255)) | 8'h01;
    s = 8'($urandom_range(1, 255));
    g = s;
    for (int k = $urandom_range(0, 5); k > 0; k--) g = mstep(g);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, s);
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) == 0)
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'($urandom_range(0, 1)), g);
      else
        send(1'($urandom_range(0, 11) == 0), 1'($urandom_range(0, 3) != 0),
             1'($urandom_range(0, 39) == 0));
      total++; if (bus.locked !== m_locked || bus.err_pulse !== m_pulse || bus.err_cnt !== 4'(m_err) ||
                   bus.bit_cnt !== 4'(m_bit) || bus.lfsr_o !== m_lfsr)
        $display("FAIL b2b cyc%0d got %0b/%0b/%0d/%0d/%0h want %0b/%0b/%0d/%0d/%0h", i,
                 bus.locked, bus.err_pulse, bus.err_cnt, bus.bit_cnt, bus.lfsr_o,
                 m_locked, m_pulse, m_err, m_bit, m_lfsr); else passed++;
    end
  endtask

  initial begin
    taps = 8'h1D;
    g = 8'hFF;
    bus.ld = 0; bus.clr = 0; bus.din = 0; bus.din_vld = 0;
    bus.lfsr_i = 0; bus.taps = taps;
    test_reset();
    test_lock_matched();
    test_offset();
    test_errors();
    test_loss();
    test_saturation();
    test_reset_load();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/galois_lfsr_checker.md
Name: galois_lfsr_checker

Overview:
- Receive-side counterpart of the Galois LFSR keystream/PRBS generator.
- Takes a serial bit stream, one bit per `din_vld`, that was produced as the generator's MSB output `k` for given taps and seed.
- Aligns a local Galois LFSR to the stream, declares lock, and counts bit errors.
- Sits at the receiving end of the link, next to the keystream/PRBS source under test.

Parameters:
- N, 32, LFSR width in bits (N >= 4).
- LOCK_CNT, 32, consecutive matches required to enter LOCKED (>= 1).
- LOSS_CNT, 8, consecutive mismatches while LOCKED that force a return to SEARCH (>= 1).
- CNT_W, 16, width of the error and bit counters.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous active-high reset.
- clr  in  1  synchronous clear of `err_cnt`, `bit_cnt` and `err_pulse` only; lock state is unaffected.
- ld  in  1  load `lfsr_i` into the local LFSR and enter SEARCH.
- taps  in  N  feedback taps; same encoding as the generator.
- lfsr_i  in  N  seed value.
- din  in  1  received stream bit.
- din_vld  in  1  `din` is valid this cycle.
- locked  out  1  high while in LOCKED.
- err_pulse  out  1  one-cycle pulse, registered, for a mismatch counted while LOCKED.
- err_cnt  out  CNT_W  mismatches counted while LOCKED; saturating.
- bit_cnt  out  CNT_W  valid bits received while LOCKED; saturating.
- lfsr_o  out  N  local LFSR state.

Behaviour:
- Step function: step(s) = {s[N-2:0],1'b0} ^ (taps & {N{s[N-1]}}).
- Expected bit: exp = lfsr[N-1].
- Reset values:
  - lfsr = all ones; state = SEARCH.
  - match_cnt = 0; miss_cnt = 0.
  - locked = 0; err_pulse = 0; err_cnt = 0; bit_cnt = 0.
- Priority: rst > ld > din_vld.
  - ld: lfsr <= lfsr_i; state <= SEARCH; match_cnt <= 0; miss_cnt <= 0; counters keep their values.
- SEARCH, on din_vld:
  - din == exp: lfsr <= step(lfsr); match_cnt++.
    - If match_cnt reaches LOCK_CNT: state <= LOCKED next cycle, match_cnt <= 0.
  - din != exp: lfsr <= step(step(lfsr)) (double step, slips local one bit ahead); match_cnt <= 0.
  - Counters do not change in SEARCH.
  - Note: a stream that started before the local seed load is eventually acquired.
- LOCKED, on din_vld:
  - lfsr <= step(lfsr) always.
  - bit_cnt++ (saturating).
  - din != exp:
    - err_cnt++ (saturating); err_pulse = 1 on the next cycle; miss_cnt++.
    - If miss_cnt reaches LOSS_CNT: state <= SEARCH, miss_cnt <= 0, match_cnt <= 0.
  - din == exp: miss_cnt <= 0.
- No din_vld: LFSR and all counters hold; err_pulse = 0.
- Latency:
  - locked asserts on the cycle after the clock edge that samples the LOCK_CNT-th match.
  - err_pulse, err_cnt and bit_cnt update 1 cycle after the sampled bit.
- Saturation: counters stop at 2^CNT_W-1 and never wrap.
- clr:
  - Zeroes err_cnt, bit_cnt and err_pulse.
  - If clr coincides with a counted bit, clr wins; that bit is not counted.
- Loss of lock:
  - The bit that triggers loss is still counted in err_cnt and bit_cnt.
  - locked drops on the next cycle.
- An all-zero local state is a degenerate case: the checker still steps; no special handling.

Test Plan:
- Lock from matched seed (N=8, taps=0x1D, generator and checker both seeded 0xFF, LOCK_CNT=4): generator states are 0xFF, 0xE3, 0xDB, 0xAB, …; feed its MSB stream with din_vld=1 every cycle → locked rises after the 4th bit; err_cnt=0; bit_cnt increments per bit thereafter.
- Offset acquisition: generator runs 3 steps ahead of the checker seed → SEARCH double-steps on mismatches; locked asserts within the length of the stream; err_cnt stays 0.
- Error injection while LOCKED: flip 2 non-adjacent bits → exactly 2 err_pulse cycles; err_cnt=2; locked stays 1.
- Loss of lock (LOSS_CNT=8): invert 8 consecutive bits → err_cnt +8; locked drops after the 8th; re-lock on clean data after LOCK_CNT matches.
- Saturation and clr (CNT_W=4): inject 20 errors while LOCKED with LOSS_CNT large → err_cnt holds at 15. Then pulse clr together with a valid error bit → err_cnt=0, bit_cnt=0.
- Reset and load mid-operation: assert rst while LOCKED → all outputs return to reset values the next cycle; lfsr_o=all ones. Assert ld together with din_vld → lfsr_o=lfsr_i; the bit is ignored.
